// File: rtl/xs3_pkg.sv
// xs3_pkg: shared FSM states, mode encodings and the excess-3 offset
package xs3_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
endpackage

// File: rtl/xs3_digit.sv
// xs3_digit: converts one 4-bit digit between BCD and excess-3 (validity flag under XS3_ERR_CHECK_EN)
module xs3_digit
  import xs3_pkg::*;
(
  input  logic [3:0] din,
  input  logic       mode,
  output logic [3:0] dout,
  output logic       invalid
);
  assign dout = (mode == MODE_XS32BCD) ? din - XS3_OFFSET : din + XS3_OFFSET;
`ifdef XS3_ERR_CHECK_EN
  assign invalid = (mode == MODE_XS32BCD) ? (din < 4'd3 || din > 4'd12) : (din > 4'd9);
`else
  assign invalid = 1'b0;
`endif
endmodule

// File: rtl/xs3_seq_conv.sv
// xs3_seq_conv: converts a packed word one digit per cycle; XS3_ERR_CHECK_EN enables the sticky err flag
module xs3_seq_conv
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  err
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] src;
  logic mode_q;
  logic [3:0] dout;
  logic last, accept;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign last = idx == IW'(DIGITS - 1);
`ifdef XS3_ERR_CHECK_EN
  logic inv;
  xs3_digit u_digit (.din(src[idx*4 +: 4]), .mode(mode_q), .dout(dout), .invalid(inv));
  always_ff @(posedge clk)
    if (!rst_n || accept) err <= 1'b0;
    else if (state == CONV) err <= err | inv;
`else
  logic unused_inv;
  xs3_digit u_digit (.din(src[idx*4 +: 4]), .mode(mode_q), .dout(dout), .invalid(unused_inv));
  assign err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? CONV : IDLE;
      CONV: state_n = last ? DONE : CONV;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      src <= '0;
      mode_q <= MODE_BCD2XS3;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        src <= in_data;
        mode_q <= mode;
        idx <= '0;
      end else if (state == CONV) begin
        out_data[idx*4 +: 4] <= dout;
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xs3_seq_conv.sv
// tb_xs3_seq_conv: directed and random words checked against an arithmetic model of the conversion
module tb_xs3_seq_conv;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, mode = 1'b0;
  logic out_valid, out_ready = 1'b0, err;
  logic [15:0] in_data = '0, out_data;
  int errors = 0, checks = 0;

  xs3_seq_conv #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_data(input logic [15:0] d, input logic m);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      int v = (d >> (4 * i)) & 15;
      r += (m ? (v + 13) % 16 : (v + 3) % 16) << (4 * i);
    end
    return 16'(r);
  endfunction

  function automatic logic model_err(input logic [15:0] d, input logic m);
    logic e = 1'b0;
`ifdef XS3_ERR_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      int v = (d >> (4 * i)) & 15;
      if (m ? (v < 3 || v > 12) : (v > 9)) e = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic accept_word(input logic [15:0] d, input logic m);
    int w = 0;
    while (!in_ready && w < 10) begin step(); w++; end
    check("ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; mode = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [15:0] d, input logic m, input int hold);
    logic [15:0] ed = model_data(d, m);
    logic ee = model_err(d, m);
    int lat = 0;
    accept_word(d, m);
    while (!out_valid && lat < 20) begin
      mode = ~mode; in_data = 16'($urandom);
      step(); lat++;
    end
    check("latency", lat, 4);
    check("out_data", out_data, ed);
    check("err", err, ee);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_data", out_data, ed);
      check("hold_err", err, ee);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consumed_valid", out_valid, 1'b0);
    check("consumed_ready", in_ready, 1'b1);
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0);
    check("rst_err", err, 1'b0);
    run_word(16'h1998, 1'b0, 0);
    run_word(16'h4CCB, 1'b1, 0);
    run_word(16'h00A0, 1'b0, 5);
    // reset in the second CONV cycle must drop the word entirely
    accept_word(16'h5678, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    check("abort_data", out_data, 16'h0);
    check("abort_err", err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", out_valid, 1'b0);
    end
    run_word(16'h0000, 1'b0, 0);
    // a word offered on the consume edge must not be taken until the next cycle
    accept_word(16'h2222, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("pre_consume_valid", out_valid, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1111; mode = 1'b0;
    step();
    out_ready = 1'b0;
    check("no_accept_on_consume", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("next_accept", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("next_data", out_data, model_data(16'h1111, 1'b0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++)
      run_word(16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
